lcd_timing_gen: RTL and testbench

//  Pixel-clock-domain raster timing generator for the 480x272 RGB LCD; consumes the ~9 MHz video PLL clock.

---
 rtl/lcd_timing_gen.sv | 135 +++++++++++++
 tb/tb_lcd_timing_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the 480x272 RGB LCD panel, clocked by the video PLL pixel clock.
// Emits registered HSYNC/VSYNC/DE, pixel coordinates and a lookahead pixel request.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 39,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 8,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIX_LEAD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       pix_req,
    output logic       frame_start,
    output logic       busy
);
    // state  | meaning
    // S_IDLE | counters parked at 0, outputs inactive, waiting for run
    // S_RUN  | generating frames, wraps straight into the next frame
    // S_STOP | run dropped, finishing the current frame before idling

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [HW-1:0] h_cnt, h_nxt, la_h, la_h_nxt;
    logic [VW-1:0] v_cnt, v_nxt, la_v, la_v_nxt;
    logic la_wrap, la_wrap_nxt;
    logic active, h_end, v_end, frame_end, la_h_end, la_v_end, la_frame_end;
    logic de_nxt, pix_req_nxt, hs_win, vs_win;

    assign active       = (state != S_IDLE);
    assign h_end        = (h_cnt == HW'(H_TOTAL - 1));
    assign v_end        = (v_cnt == VW'(V_TOTAL - 1));
    assign frame_end    = h_end && v_end;
    assign la_h_end     = (la_h == HW'(H_TOTAL - 1));
    assign la_v_end     = (la_v == VW'(V_TOTAL - 1));
    assign la_frame_end = la_h_end && la_v_end;

    // Lookahead runs PIX_LEAD positions ahead; once it has crossed into the next
    // frame, its pixels only count if the frame is going to continue.
    assign de_nxt      = active && (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign pix_req_nxt = active && (la_h < HW'(H_ACTIVE)) && (la_v < VW'(V_ACTIVE))
                         && (!la_wrap || run);
    assign hs_win      = active && (h_cnt >= HW'(H_ACTIVE + H_FP))
                         && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_win      = active && (v_cnt >= VW'(V_ACTIVE + V_FP))
                         && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

    always_comb begin
        state_nxt   = state;
        h_nxt       = h_cnt;
        v_nxt       = v_cnt;
        la_h_nxt    = la_h;
        la_v_nxt    = la_v;
        la_wrap_nxt = la_wrap;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_RUN;
            end
            S_RUN, S_STOP: begin
                h_nxt    = h_end ? '0 : h_cnt + HW'(1);
                v_nxt    = h_end ? (v_end ? '0 : v_cnt + VW'(1)) : v_cnt;
                la_h_nxt = la_h_end ? '0 : la_h + HW'(1);
                la_v_nxt = la_h_end ? (la_v_end ? '0 : la_v + VW'(1)) : la_v;
                if (frame_end)         la_wrap_nxt = 1'b0;
                else if (la_frame_end) la_wrap_nxt = 1'b1;
                if (run)            state_nxt = S_RUN;
                else if (frame_end) state_nxt = S_IDLE;
                else                state_nxt = S_STOP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
            la_h    <= HW'(PIX_LEAD);
            la_v    <= '0;
            la_wrap <= 1'b0;
        end else begin
            state   <= state_nxt;
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            la_h    <= la_h_nxt;
            la_v    <= la_v_nxt;
            la_wrap <= la_wrap_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de          <= 1'b0;
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            x           <= '0;
            y           <= '0;
        end else begin
            de          <= de_nxt;
            pix_req     <= pix_req_nxt;
            frame_start <= active && (h_cnt == '0) && (v_cnt == '0);
            busy        <= active;
            hsync       <= hs_win ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_win ? SYNC_POL : ~SYNC_POL;
            if (de_nxt) begin
                x <= 9'(h_cnt);
                y <= 9'(v_cnt);
            end
        end
    end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a shrunken raster, checked against a linear frame-position model.
// Two instances share stimulus: one with a 2-clock pixel-request lead and one with no lead.
module tb_lcd_timing_gen;
    localparam int HA = 16, HF = 3, HS = 2, HB = 4;
    localparam int VA = 6, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int LEAD = 2;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic hs_a, vs_a, de_a, pr_a, fs_a, busy_a;
    logic hs_b, vs_b, de_b, pr_b, fs_b, busy_b;
    logic [8:0] x_a, y_a, x_b, y_b;

    lcd_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .SYNC_POL(1'b0), .PIX_LEAD(LEAD)) dut_a (
        .clk(clk), .rst(rst), .run(run), .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .x(x_a), .y(y_a), .pix_req(pr_a), .frame_start(fs_a), .busy(busy_a));

    lcd_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .SYNC_POL(1'b0), .PIX_LEAD(0)) dut_b (
        .clk(clk), .rst(rst), .run(run), .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .x(x_b), .y(y_b), .pix_req(pr_b), .frame_start(fs_b), .busy(busy_b));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit m_active = 1'b0;
    int m_pos    = 0;
    bit e_de, e_hs, e_vs, e_fs, e_busy;
    int e_x = 0, e_y = 0;
    bit exp_de_h[MAXC];
    bit exp_busy_h[MAXC];
    bit rst_h[MAXC];
    bit pr_h[MAXC];

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    // Outputs for the position held last cycle, then advance; only run at the
    // last position of a frame decides whether another frame follows.
    task automatic model_step();
        int h, v;
        if (rst) begin
            m_active = 1'b0; m_pos = 0;
            e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_busy = 1'b0;
            e_x = 0; e_y = 0;
        end else begin
            h = m_pos % HT;
            v = m_pos / HT;
            e_de   = m_active && (h < HA) && (v < VA);
            e_hs   = !(m_active && (h >= HA + HF) && (h < HA + HF + HS));
            e_vs   = !(m_active && (v >= VA + VF) && (v < VA + VF + VS));
            e_fs   = m_active && (m_pos == 0);
            e_busy = m_active;
            if (e_de) begin e_x = h; e_y = v; end
            if (!m_active) begin
                if (run) begin m_active = 1'b1; m_pos = 0; end
            end else if (m_pos == FR - 1) begin
                m_pos = 0; m_active = run;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check("de",          de_a,   e_de);
        check("hsync",       hs_a,   e_hs);
        check("vsync",       vs_a,   e_vs);
        check("x",           x_a,    e_x);
        check("y",           y_a,    e_y);
        check("frame_start", fs_a,   e_fs);
        check("busy",        busy_a, e_busy);
        check("de_l0",       de_b,   e_de);
        check("hsync_l0",    hs_b,   e_hs);
        check("vsync_l0",    vs_b,   e_vs);
        check("x_l0",        x_b,    e_x);
        check("y_l0",        y_b,    e_y);
        check("fs_l0",       fs_b,   e_fs);
        check("busy_l0",     busy_b, e_busy);
        check("pix_req_l0",  pr_b,   e_de);
        if (cyc < MAXC) begin
            exp_de_h[cyc]   = e_de;
            exp_busy_h[cyc] = e_busy;
            rst_h[cyc]      = rst;
            pr_h[cyc]       = pr_a;
            // a reset inside the lead window legitimately cancels a promised pixel
            if (cyc >= LEAD && !rst_h[cyc] && !rst_h[cyc-1])
                check("pix_req_l2", pr_h[cyc-LEAD],
                      int'(exp_de_h[cyc] && exp_busy_h[cyc-LEAD]));
        end
        cyc++;
    endtask

    task automatic wait_pos(input int target, input int limit);
        int n = 0;
        while (!(m_active && m_pos == target) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) check("wait_pos_timeout", n, limit - 1);
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b1;
        repeat (5) tick();
        rst = 1'b0;

        // stop mid-frame then resume before the frame ends
        wait_pos(2 * HT + 5, 2 * FR);
        run = 1'b0;
        wait_pos(4 * HT + 5, FR);
        run = 1'b1;
        // stop and let the frame run out into idle
        wait_pos(2 * HT, 2 * FR);
        run = 1'b0;
        repeat (FR + 50) tick();

        // restart, then reset in the middle of a visible line
        run = 1'b1;
        wait_pos(3 * HT + 12, 2 * FR);
        #2;
        rst = 1'b1;
        #1;
        check("rst_de",      de_a,   0);
        check("rst_pix_req", pr_a,   0);
        check("rst_busy",    busy_a, 0);
        check("rst_fs",      fs_a,   0);
        check("rst_hsync",   hs_a,   1);
        check("rst_vsync",   vs_a,   1);
        check("rst_x",       x_a,    0);
        check("rst_y",       y_a,    0);
        repeat (2) tick();
        rst = 1'b0;

        repeat (2500) begin
            if ($urandom_range(0, 149) == 0 && !(m_active && m_pos >= FR - 6))
                run = ~run;
            tick();
        end

        run = 1'b0;
        repeat (FR + 20) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
